// File: rtl/bus_mux_hold_if.sv
// rtl/bus_mux_hold_if.sv - shared-bus source/enable and result signals for bus_mux_hold
`timescale 1ns/1ps
interface bus_mux_hold_if #(
   parameter int N = 24,
   parameter int W = 32
);
   localparam int SW = (N > 1) ? $clog2(N) : 1;

   logic [N*W-1:0] bus_in;
   logic [N-1:0]   out_en;
   logic [W-1:0]   bus_out;
   logic           bus_valid;
   logic [SW-1:0]  sel_idx;
   logic           conflict;

   modport master (
      output bus_in, out_en,
      input  bus_out, bus_valid, sel_idx, conflict
   );

   modport slave (
      input  bus_in, out_en,
      output bus_out, bus_valid, sel_idx, conflict
   );
endinterface

// File: rtl/bus_mux_hold.sv
// rtl/bus_mux_hold.sv - priority bus multiplexer with hold register and conflict tracking
`timescale 1ns/1ps
module bus_mux_hold #(
   parameter int N       = 24,
   parameter int W       = 32,
   parameter bit REG_OUT = 1'b0,
   parameter int CNT_W   = 8
) (
   input  logic             clock,
   input  logic             clear,
   bus_mux_hold_if.slave    bus,
   input  logic             err_clr,
   output logic             err_sticky,
   output logic [CNT_W-1:0] err_cnt,
   output logic [N-1:0]     err_en_cap
);
   localparam int SW = (N > 1) ? $clog2(N) : 1;

   logic [SW-1:0] win;
   logic [W-1:0]  win_data;
   logic          any;
   logic          multi;
   logic [W-1:0]  hold_q;
   logic [SW-1:0] last_win_q;
   logic [W-1:0]  mux_data;
   logic          mux_valid;
   logic [SW-1:0] mux_sel;

   // Priority select: scanning upward lets the highest enabled index overwrite earlier hits
   always_comb begin
      win      = '0;
      win_data = '0;
      any      = 1'b0;
      multi    = 1'b0;
      for (int i = 0; i < N; i++) begin
         if (bus.out_en[i]) begin
            multi    = multi | any;
            any      = 1'b1;
            win      = SW'(i);
            win_data = bus.bus_in[i*W +: W];
         end
      end
   end

   // Bus value before the optional output stage; idle cycles fall back to the held value and index
   always_comb begin
      mux_data  = hold_q;
      mux_valid = 1'b0;
      mux_sel   = last_win_q;
      if (any) begin
         mux_data  = win_data;
         mux_valid = 1'b1;
         mux_sel   = win;
      end
   end

   // Hold register remembers the last driven value and its source index
   always_ff @(posedge clock or negedge clear) begin
      if (!clear) begin
         hold_q     <= '0;
         last_win_q <= '0;
      end else if (any) begin
         hold_q     <= win_data;
         last_win_q <= win;
      end
   end

   generate
      if (REG_OUT) begin : g_reg
         logic [W-1:0]  out_q;
         logic          valid_q;
         logic [SW-1:0] sel_q;

         // Output stage: a drive in cycle t shows at t+1 and is re-registered from hold while idle
         always_ff @(posedge clock or negedge clear) begin
            if (!clear) begin
               out_q   <= '0;
               valid_q <= 1'b0;
               sel_q   <= '0;
            end else begin
               out_q   <= mux_data;
               valid_q <= mux_valid;
               sel_q   <= mux_sel;
            end
         end

         assign bus.bus_out   = out_q;
         assign bus.bus_valid = valid_q;
         assign bus.sel_idx   = sel_q;
      end else begin : g_comb
         // Combinational path is forced to the reset value while clear is low so reset acts at once
         assign bus.bus_out   = clear ? mux_data  : '0;
         assign bus.bus_valid = clear ? mux_valid : 1'b0;
         assign bus.sel_idx   = clear ? mux_sel   : '0;
      end
   endgenerate

   assign bus.conflict = multi;

   // Sticky error state: err_clr beats a same-cycle conflict; capture only the first offending vector
   always_ff @(posedge clock or negedge clear) begin
      if (!clear) begin
         err_sticky <= 1'b0;
         err_cnt    <= '0;
         err_en_cap <= '0;
      end else if (err_clr) begin
         err_sticky <= 1'b0;
         err_cnt    <= '0;
         err_en_cap <= '0;
      end else if (multi) begin
         err_sticky <= 1'b1;
         if (err_cnt != {CNT_W{1'b1}}) begin
            err_cnt <= err_cnt + CNT_W'(1);
         end
         if (!err_sticky) begin
            err_en_cap <= bus.out_en;
         end
      end
   end
endmodule

// File: tb/tb_bus_mux_hold.sv
// tb/tb_bus_mux_hold.sv - table-driven bench with scoreboard for bus_mux_hold
`timescale 1ns/1ps
module tb_bus_mux_hold;
   typedef struct {
      logic [23:0] en;
      int          ov_idx;
      logic [31:0] ov_val;
      logic        clr;
      logic [31:0] out;
      logic        valid;
      logic [4:0]  sel;
      logic        conf;
      logic        sticky;
      logic [7:0]  cnt;
      logic [1:0]  cnt2;
      logic [23:0] cap;
   } vec_t;

   typedef struct {
      logic [31:0] data;
      logic        valid;
      logic [4:0]  sel;
   } exp_t;

   logic clk = 1'b0;
   logic clear;
   logic err_clr;
   logic [24*32-1:0] bus_in;
   logic [23:0]      out_en;
   logic [24*32-1:0] base_bus;
   logic [23:0]      bus_in2;
   logic [2:0]       en2;

   logic        sticky0, sticky1, sticky2;
   logic [7:0]  cnt0, cnt2v;
   logic [1:0]  cnt1;
   logic [23:0] cap0, cap1;
   logic [2:0]  cap2;

   int n_vec = 0;
   int n_bad = 0;
   vec_t tbl[$];
   exp_t sb_q[$];

   always #5 clk = ~clk;

   bus_mux_hold_if #(.N(24), .W(32)) if0();
   bus_mux_hold_if #(.N(24), .W(32)) if1();
   bus_mux_hold_if #(.N(3),  .W(8))  if2();

   assign if0.bus_in = bus_in;
   assign if0.out_en = out_en;
   assign if1.bus_in = bus_in;
   assign if1.out_en = out_en;
   assign if2.bus_in = bus_in2;
   assign if2.out_en = en2;

   bus_mux_hold #(.N(24), .W(32), .REG_OUT(1'b0), .CNT_W(8)) dut0 (
      .clock(clk), .clear(clear), .bus(if0), .err_clr(err_clr),
      .err_sticky(sticky0), .err_cnt(cnt0), .err_en_cap(cap0));

   bus_mux_hold #(.N(24), .W(32), .REG_OUT(1'b1), .CNT_W(2)) dut1 (
      .clock(clk), .clear(clear), .bus(if1), .err_clr(err_clr),
      .err_sticky(sticky1), .err_cnt(cnt1), .err_en_cap(cap1));

   bus_mux_hold #(.N(3), .W(8), .REG_OUT(1'b0), .CNT_W(8)) dut2 (
      .clock(clk), .clear(clear), .bus(if2), .err_clr(err_clr),
      .err_sticky(sticky2), .err_cnt(cnt2v), .err_en_cap(cap2));

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
      n_vec++;
      if (act !== exp_v) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp_v);
      end
   endtask

   function automatic vec_t mk(input logic [23:0] en, input int ov_idx, input logic [31:0] ov_val,
                               input logic clr, input logic [31:0] out, input logic valid,
                               input logic [4:0] sel, input logic conf, input logic sticky,
                               input logic [7:0] cnt, input logic [1:0] cnt2, input logic [23:0] cap);
      vec_t v;
      v.en = en; v.ov_idx = ov_idx; v.ov_val = ov_val; v.clr = clr;
      v.out = out; v.valid = valid; v.sel = sel; v.conf = conf;
      v.sticky = sticky; v.cnt = cnt; v.cnt2 = cnt2; v.cap = cap;
      return v;
   endfunction

   // One bus cycle: starts just after a rising edge and ends just after the next one
   task automatic step(input vec_t v);
      logic [24*32-1:0] bi;
      exp_t e;
      bi = base_bus;
      if (v.ov_idx >= 0) bi[v.ov_idx*32 +: 32] = v.ov_val;
      bus_in  = bi;
      out_en  = v.en;
      err_clr = v.clr;
      e.data  = v.out;
      e.valid = v.valid;
      e.sel   = v.sel;
      sb_q.push_back(e);
      #3;
      chk("bus_out",   if0.bus_out,   v.out);
      chk("bus_valid", if0.bus_valid, v.valid);
      chk("sel_idx",   if0.sel_idx,   v.sel);
      chk("conflict",  if0.conflict,  v.conf);
      chk("conflict_r", if1.conflict, v.conf);
      @(posedge clk);
      #1;
      chk("err_sticky", sticky0, v.sticky);
      chk("err_cnt",    cnt0,    v.cnt);
      chk("err_en_cap", cap0,    v.cap);
      chk("err_sticky_r", sticky1, v.sticky);
      chk("err_cnt_sat",  cnt1,    v.cnt2);
      chk("err_en_cap_r", cap1,    v.cap);
      if (sb_q.size() == 0) begin
         chk("scoreboard_empty", 32'd0, 32'd1);
      end else begin
         e = sb_q.pop_front();
         chk("bus_out_r",   if1.bus_out,   e.data);
         chk("bus_valid_r", if1.bus_valid, e.valid);
         chk("sel_idx_r",   if1.sel_idx,   e.sel);
      end
      err_clr = 1'b0;
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_bus_out"},    if0.bus_out,   32'd0);
      chk({tag, "_bus_valid"},  if0.bus_valid, 32'd0);
      chk({tag, "_sel_idx"},    if0.sel_idx,   32'd0);
      chk({tag, "_bus_out_r"},  if1.bus_out,   32'd0);
      chk({tag, "_bus_valid_r"}, if1.bus_valid, 32'd0);
      chk({tag, "_sel_idx_r"},  if1.sel_idx,   32'd0);
      chk({tag, "_sticky"},     sticky0,       32'd0);
      chk({tag, "_cnt"},        cnt0,          32'd0);
      chk({tag, "_cap"},        cap0,          32'd0);
      chk({tag, "_cnt_r"},      cnt1,          32'd0);
      chk({tag, "_cap_r"},      cap1,          32'd0);
      chk({tag, "_bus_out2"},   if2.bus_out,   32'd0);
   endtask

   initial begin
      for (int i = 0; i < 24; i++) base_bus[i*32 +: 32] = 32'hC0DE_0000 | 32'(i);

      // Vector table: expected error fields are the values after the cycle's clock edge
      tbl.push_back(mk(24'h0, -1, 32'h0, 1'b0, 32'h0, 1'b0, 5'd0, 1'b0, 1'b0, 8'd0, 2'd0, 24'h0));
      tbl.push_back(mk(24'h000010, 4, 32'hDEADBEEF, 1'b0, 32'hDEADBEEF, 1'b1, 5'd4, 1'b0, 1'b0, 8'd0, 2'd0, 24'h0));
      for (int k = 1; k <= 5; k++)
         tbl.push_back(mk(24'h0, 4, 32'(k), 1'b0, 32'hDEADBEEF, 1'b0, 5'd4, 1'b0, 1'b0, 8'd0, 2'd0, 24'h0));
      tbl.push_back(mk(24'h080004, 19, 32'h5, 1'b0, 32'h5, 1'b1, 5'd19, 1'b1, 1'b1, 8'd1, 2'd1, 24'h080004));
      tbl.push_back(mk(24'h000083, -1, 32'h0, 1'b0, 32'hC0DE0007, 1'b1, 5'd7, 1'b1, 1'b1, 8'd2, 2'd2, 24'h080004));
      tbl.push_back(mk(24'h800000, -1, 32'h0, 1'b0, 32'hC0DE0017, 1'b1, 5'd23, 1'b0, 1'b1, 8'd2, 2'd2, 24'h080004));
      tbl.push_back(mk(24'hFFFFFF, -1, 32'h0, 1'b0, 32'hC0DE0017, 1'b1, 5'd23, 1'b1, 1'b1, 8'd3, 2'd3, 24'h080004));
      tbl.push_back(mk(24'h000060, -1, 32'h0, 1'b0, 32'hC0DE0006, 1'b1, 5'd6, 1'b1, 1'b1, 8'd4, 2'd3, 24'h080004));
      tbl.push_back(mk(24'h800001, -1, 32'h0, 1'b0, 32'hC0DE0017, 1'b1, 5'd23, 1'b1, 1'b1, 8'd5, 2'd3, 24'h080004));
      tbl.push_back(mk(24'h000011, -1, 32'h0, 1'b0, 32'hC0DE0004, 1'b1, 5'd4, 1'b1, 1'b1, 8'd6, 2'd3, 24'h080004));
      tbl.push_back(mk(24'h000208, -1, 32'h0, 1'b1, 32'hC0DE0009, 1'b1, 5'd9, 1'b1, 1'b0, 8'd0, 2'd0, 24'h0));
      tbl.push_back(mk(24'h0, -1, 32'h0, 1'b0, 32'hC0DE0009, 1'b0, 5'd9, 1'b0, 1'b0, 8'd0, 2'd0, 24'h0));
      tbl.push_back(mk(24'h000006, -1, 32'h0, 1'b0, 32'hC0DE0002, 1'b1, 5'd2, 1'b1, 1'b1, 8'd1, 2'd1, 24'h000006));
      tbl.push_back(mk(24'h000001, -1, 32'h0, 1'b0, 32'hC0DE0000, 1'b1, 5'd0, 1'b0, 1'b1, 8'd1, 2'd1, 24'h000006));
      tbl.push_back(mk(24'h000001, 0, 32'h12345678, 1'b0, 32'h12345678, 1'b1, 5'd0, 1'b0, 1'b1, 8'd1, 2'd1, 24'h000006));
      tbl.push_back(mk(24'h0, 0, 32'h0BADF00D, 1'b0, 32'h12345678, 1'b0, 5'd0, 1'b0, 1'b1, 8'd1, 2'd1, 24'h000006));

      // Reset with live stimulus: outputs must be zero before any clock edge
      clear   = 1'b0;
      err_clr = 1'b0;
      out_en  = 24'($urandom) | 24'h1;
      for (int i = 0; i < 24; i++) bus_in[i*32 +: 32] = $urandom;
      en2     = 3'b101;
      bus_in2 = 24'($urandom);
      #2;
      chk_reset("reset");
      @(posedge clk);
      #1;
      clear   = 1'b1;
      out_en  = '0;
      en2     = '0;
      bus_in2 = 24'h332211;

      foreach (tbl[j]) step(tbl[j]);

      for (int i = 0; i < 24; i++)
         step(mk(24'(1) << i, -1, 32'h0, 1'b0, 32'hC0DE0000 | 32'(i), 1'b1, 5'(i), 1'b0,
                 1'b1, 8'd1, 2'd1, 24'h000006));

      // Mid-operation reset while a source drives: immediate clear, then idle with cleared hold
      bus_in = base_bus;
      out_en = 24'h000010;
      #2;
      clear = 1'b0;
      #1;
      chk_reset("midreset");
      @(posedge clk);
      #1;
      clear = 1'b1;
      sb_q.delete();
      step(mk(24'h0, -1, 32'h0, 1'b0, 32'h0, 1'b0, 5'd0, 1'b0, 1'b0, 8'd0, 2'd0, 24'h0));

      // Narrow instance sweep, then a conflict and an idle hold
      for (int i = 0; i < 3; i++) begin
         en2 = 3'(1 << i);
         #3;
         chk("n3_bus_out",  if2.bus_out,  32'h11 * 32'(i + 1));
         chk("n3_sel_idx",  if2.sel_idx,  32'(i));
         chk("n3_valid",    if2.bus_valid, 32'd1);
         chk("n3_conflict", if2.conflict, 32'd0);
         @(posedge clk);
         #1;
      end
      en2 = 3'b011;
      #3;
      chk("n3_conf_bus_out", if2.bus_out,  32'h22);
      chk("n3_conf_sel",     if2.sel_idx,  32'd1);
      chk("n3_conf_flag",    if2.conflict, 32'd1);
      @(posedge clk);
      #1;
      en2 = 3'b000;
      bus_in2 = 24'h0;
      #3;
      chk("n3_hold_bus_out", if2.bus_out,   32'h22);
      chk("n3_hold_valid",   if2.bus_valid, 32'd0);
      chk("n3_hold_sel",     if2.sel_idx,   32'd1);
      chk("n3_err_sticky",   sticky2,       32'd1);
      chk("n3_err_cap",      cap2,          32'h3);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
